// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the mac8 sequencer.
package mac_seq_pkg;

  localparam int ACC_W     = 32;
  localparam int OP_W      = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUTPUT
  } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand, mac8 and result signals of the sequencer.
// slave = controller side, master = environment (fetch buffers, mac8, consumer).
interface mac_seq_ctrl_if
  import mac_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic                    start;
  logic [CNT_W-1:0]        cfg_k;
  logic                    busy;
  logic                    op_valid;
  logic                    op_ready;
  logic signed [OP_W-1:0]  op_a;
  logic signed [OP_W-1:0]  op_b;
  logic signed [OP_W-1:0]  mac_a;
  logic signed [OP_W-1:0]  mac_b;
  logic                    mac_en;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] mac_acc;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [ACC_W-1:0] res_data;
  logic                    done;
  logic [ACC_W-1:0]        perf_stall_cnt;

  modport slave (
    input  start, cfg_k, op_valid, op_a, op_b, mac_acc, res_ready,
    output busy, op_ready, mac_a, mac_b, mac_en, mac_clr,
           res_valid, res_data, done, perf_stall_cnt
  );

  modport master (
    output start, cfg_k, op_valid, op_a, op_b, mac_acc, res_ready,
    input  busy, op_ready, mac_a, mac_b, mac_en, mac_clr,
           res_valid, res_data, done, perf_stall_cnt
  );

endinterface

// File: rtl/mac8.sv
// Signed 8x8->32 multiply-accumulate, 1-cycle latency, synchronous clear.
// Zero operands skip the accumulate; the sum is unchanged either way.
module mac8
  import mac_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*OP_W-1:0] w_prod;
  assign w_prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en && (a != '0) && (b != '0)) begin
      acc <= acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one mac8: CLEAR, stream K operand pairs, DRAIN, hand off result.
// Optional stall counter enabled by defining MAC_SEQ_PERF_EN.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_seq_ctrl_if.slave        bus
);

  mac_seq_state_e          r_state;
  mac_seq_state_e          w_next;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        r_k;
  logic signed [ACC_W-1:0] r_res_data;
  logic                    w_xfer;
  logic                    w_last;

  assign w_xfer = (r_state == RUN) && bus.op_valid;
  assign w_last = (r_count == r_k - CNT_W'(1));

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets its default before the case so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = CLEAR;
      CLEAR:   w_next = (r_k == '0) ? DRAIN : RUN;
      RUN:     if (w_xfer && w_last) w_next = DRAIN;
      DRAIN:   w_next = OUTPUT;
      OUTPUT:  if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_k        <= '0;
      r_res_data <= '0;
    end else begin
      if (r_state == IDLE && bus.start) r_k <= bus.cfg_k;
      if (r_state == CLEAR) begin
        r_count <= '0;
      end else if (w_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end
      // mac8 has absorbed the final pair by the DRAIN cycle
      if (r_state == DRAIN) r_res_data <= bus.mac_acc;
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.op_ready  = (r_state == RUN);
  assign bus.mac_clr   = (r_state == CLEAR);
  assign bus.mac_en    = w_xfer;
  assign bus.mac_a     = w_xfer ? bus.op_a : '0;
  assign bus.mac_b     = w_xfer ? bus.op_b : '0;
  assign bus.res_valid = (r_state == OUTPUT);
  assign bus.res_data  = r_res_data;
  assign bus.done      = (r_state == OUTPUT) && bus.res_ready;

`ifdef MAC_SEQ_PERF_EN
  logic [ACC_W-1:0] r_perf_stall_cnt;
  logic             w_stall;

  assign w_stall = ((r_state == RUN) && !bus.op_valid) ||
                   ((r_state == OUTPUT) && !bus.res_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
    end else if (w_stall && (r_perf_stall_cnt != '1)) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + ACC_W'(1);
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
`else
  assign bus.perf_stall_cnt = '0;
`endif

endmodule
